// File: rtl/match_iter_pkg.sv
// Shared types and width helpers for match_bit_iterator and its set-bit finder.
package match_iter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Beat fields are sized for the widest supported configuration; users narrow them.
    localparam int unsigned BEAT_IDX_MAX = 16;
    localparam int unsigned BEAT_TAG_MAX = 64;

    typedef struct packed {
        logic [BEAT_IDX_MAX-1:0] index;
        logic [BEAT_TAG_MAX-1:0] tag;
        logic                    none;
        logic                    last;
        logic                    trunc;
    } beat_t;

    function automatic int unsigned idx_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/match_bit_iterator_first_set_finder.sv
// Combinational first-set-bit finder in either direction, plus "at most one bit set" flag.
module first_set_finder
    import match_iter_pkg::*;
#(
    parameter int unsigned W         = 16,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned IW       = idx_width(W)
) (
    input  logic [W-1:0]  vec,
    output logic          found,
    output logic [IW-1:0] index,
    output logic          onehot_or_zero
);

    // Scan toward the preferred end so the last hit written wins.
    always_comb begin
        found          = |vec;
        index          = '0;
        onehot_or_zero = ((vec & (vec - W'(1))) == '0);
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(W); i++) begin
                if (vec[i]) index = IW'(i);
            end
        end else begin
            for (int i = int'(W) - 1; i >= 0; i--) begin
                if (vec[i]) index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/match_bit_iterator.sv
// Streams the index of every set bit of an accepted vector, one beat per handshake.
// Optional stats counters: define MATCH_BIT_ITER_STATS_EN.
module match_bit_iterator
    import match_iter_pkg::*;
#(
    parameter int unsigned W         = 16,
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned MAX_OUT   = W,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned IW       = idx_width(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_vec,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_index,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_none,
    output logic             out_last,
    output logic             out_trunc
`ifdef MATCH_BIT_ITER_STATS_EN
    ,
    output logic [31:0]      stat_vec_cnt,
    output logic [31:0]      stat_beat_cnt
`endif
);

    localparam int unsigned CW = cnt_width(MAX_OUT);

    state_t           state_q, state_d;
    logic [W-1:0]     res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             found;
    logic [IW-1:0]    idx;
    logic             one_or_zero;
    logic             scan, at_cap, hs, done, accept;
    beat_t            beat;
    logic             unused_beat;

    first_set_finder #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_finder (
        .vec            (res_q),
        .found          (found),
        .index          (idx),
        .onehot_or_zero (one_or_zero)
    );

    // Current beat, derived purely from registered state.
    always_comb begin
        scan   = (state_q == SCAN);
        at_cap = (cnt_q == CW'(MAX_OUT - 1));
        beat   = '0;
        if (scan) begin
            beat.index = BEAT_IDX_MAX'(idx);
            beat.tag   = BEAT_TAG_MAX'(tag_q);
            beat.none  = !found;
            beat.last  = one_or_zero || at_cap;
            beat.trunc = at_cap && !one_or_zero;
        end
    end

    assign out_valid   = scan;
    assign out_index   = IW'(beat.index);
    assign out_tag     = TAG_W'(beat.tag);
    assign out_none    = beat.none;
    assign out_last    = beat.last;
    assign out_trunc   = beat.trunc;
    assign unused_beat = ^beat;

    // Next state: flush beats everything, then accept (incl. back-to-back), then beat retire.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        hs       = scan && out_ready;
        done     = hs && beat.last;
        in_ready = !flush && (!scan || done);
        accept   = in_valid && in_ready;
        if (flush) begin
            state_d = IDLE;
            res_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = SCAN;
            res_d   = in_vec;
            cnt_d   = '0;
            tag_d   = in_tag;
        end else if (done) begin
            state_d = IDLE;
            res_d   = '0;
            cnt_d   = '0;
        end else if (hs) begin
            res_d = res_q & ~(W'(1) << idx);
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

`ifdef MATCH_BIT_ITER_STATS_EN
    // Saturating activity counters; survive flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_vec_cnt  <= '0;
            stat_beat_cnt <= '0;
        end else begin
            if (accept && (stat_vec_cnt != '1)) stat_vec_cnt <= stat_vec_cnt + 32'd1;
            if (hs && (stat_beat_cnt != '1)) stat_beat_cnt <= stat_beat_cnt + 32'd1;
        end
    end
`else
    // No stats hardware in this build.
`endif

endmodule

// File: tb/tb_match_bit_iterator.sv
// Directed bench for match_bit_iterator: four shared-stimulus instances with differing parameters.
module tb_match_bit_iterator;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [15:0] in_vec;
    logic [7:0]  in_tag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // a: defaults, b: MSB first, c: MAX_OUT=2, d: W=2 MAX_OUT=1
    logic       a_in_ready, a_out_valid, a_out_none, a_out_last, a_out_trunc;
    logic [3:0] a_out_index;
    logic [7:0] a_out_tag;
    logic       b_in_ready, b_out_valid, b_out_none, b_out_last, b_out_trunc;
    logic [3:0] b_out_index;
    logic [7:0] b_out_tag;
    logic       c_in_ready, c_out_valid, c_out_none, c_out_last, c_out_trunc;
    logic [3:0] c_out_index;
    logic [7:0] c_out_tag;
    logic       d_in_ready, d_out_valid, d_out_none, d_out_last, d_out_trunc;
    logic [0:0] d_out_index;
    logic [7:0] d_out_tag;
`ifdef MATCH_BIT_ITER_STATS_EN
    logic [31:0] a_svec, a_sbeat, b_svec, b_sbeat, c_svec, c_sbeat, d_svec, d_sbeat;
`endif

    match_bit_iterator u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_vec(in_vec), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_index(a_out_index), .out_tag(a_out_tag), .out_none(a_out_none),
        .out_last(a_out_last), .out_trunc(a_out_trunc)
`ifdef MATCH_BIT_ITER_STATS_EN
        , .stat_vec_cnt(a_svec), .stat_beat_cnt(a_sbeat)
`endif
    );

    match_bit_iterator #(.MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_vec(in_vec), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_index(b_out_index), .out_tag(b_out_tag), .out_none(b_out_none),
        .out_last(b_out_last), .out_trunc(b_out_trunc)
`ifdef MATCH_BIT_ITER_STATS_EN
        , .stat_vec_cnt(b_svec), .stat_beat_cnt(b_sbeat)
`endif
    );

    match_bit_iterator #(.MAX_OUT(2)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_vec(in_vec), .in_tag(in_tag), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_index(c_out_index), .out_tag(c_out_tag), .out_none(c_out_none),
        .out_last(c_out_last), .out_trunc(c_out_trunc)
`ifdef MATCH_BIT_ITER_STATS_EN
        , .stat_vec_cnt(c_svec), .stat_beat_cnt(c_sbeat)
`endif
    );

    match_bit_iterator #(.W(2), .MAX_OUT(1)) u_d (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_vec(in_vec[1:0]), .in_tag(in_tag), .out_valid(d_out_valid), .out_ready(out_ready),
        .out_index(d_out_index), .out_tag(d_out_tag), .out_none(d_out_none),
        .out_last(d_out_last), .out_trunc(d_out_trunc)
`ifdef MATCH_BIT_ITER_STATS_EN
        , .stat_vec_cnt(d_svec), .stat_beat_cnt(d_sbeat)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat_chk(input string nm,
                            input logic v, input logic [3:0] i, input logic l, input logic t,
                            input logic n, input logic [7:0] g,
                            input logic ev, input logic [3:0] ei, input logic el, input logic et,
                            input logic en, input logic [7:0] eg);
        check({nm, ".valid"}, 32'(v), 32'(ev));
        check({nm, ".index"}, 32'(i), 32'(ei));
        check({nm, ".last"},  32'(l), 32'(el));
        check({nm, ".trunc"}, 32'(t), 32'(et));
        check({nm, ".none"},  32'(n), 32'(en));
        check({nm, ".tag"},   32'(g), 32'(eg));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves every instance in IDLE with flush deasserted.
    task automatic flush_all();
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_vec = '0; in_tag = '0;
        tick(); tick();
        #1;
        beat_chk("reset", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag,
                 0, 4'd0, 0, 0, 0, 8'h00);
        check("reset.in_ready", 32'(a_in_ready), 32'd1);
        rst_n = 1'b1;

        // 8421 ascending under continuous ready
        tick();
        in_valid = 1'b1; in_vec = 16'h8421; in_tag = 8'h11; out_ready = 1'b1;
        #1 check("t1.in_ready", 32'(a_in_ready), 32'd1);
        tick(); in_valid = 1'b0; #1;
        beat_chk("t1.b0", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag, 1, 4'd0, 0, 0, 0, 8'h11);
        tick(); #1;
        beat_chk("t1.b1", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag, 1, 4'd5, 0, 0, 0, 8'h11);
        tick(); #1;
        beat_chk("t1.b2", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag, 1, 4'd10, 0, 0, 0, 8'h11);
        tick(); #1;
        beat_chk("t1.b3", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag, 1, 4'd15, 1, 0, 0, 8'h11);
        tick(); #1;
        check("t1.idle", 32'(a_out_valid), 32'd0);

        // MSB-first ordering
        flush_all();
        in_valid = 1'b1; in_vec = 16'h0006; in_tag = 8'h22;
        tick(); in_valid = 1'b0; #1;
        beat_chk("t2.b0", b_out_valid, b_out_index, b_out_last, b_out_trunc, b_out_none, b_out_tag, 1, 4'd2, 0, 0, 0, 8'h22);
        tick(); #1;
        beat_chk("t2.b1", b_out_valid, b_out_index, b_out_last, b_out_trunc, b_out_none, b_out_tag, 1, 4'd1, 1, 0, 0, 8'h22);
        tick(); #1;
        check("t2.idle", 32'(b_out_valid), 32'd0);

        // all-zero vector
        flush_all();
        in_valid = 1'b1; in_vec = 16'h0000; in_tag = 8'h5A;
        tick(); in_valid = 1'b0; #1;
        beat_chk("t3.b0", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag, 1, 4'd0, 1, 0, 1, 8'h5A);
        tick(); #1;
        check("t3.idle", 32'(a_out_valid), 32'd0);

        // beat cap with truncation
        flush_all();
        in_valid = 1'b1; in_vec = 16'h00F0; in_tag = 8'h44;
        tick(); in_valid = 1'b0; #1;
        beat_chk("t4.b0", c_out_valid, c_out_index, c_out_last, c_out_trunc, c_out_none, c_out_tag, 1, 4'd4, 0, 0, 0, 8'h44);
        tick(); #1;
        beat_chk("t4.b1", c_out_valid, c_out_index, c_out_last, c_out_trunc, c_out_none, c_out_tag, 1, 4'd5, 1, 1, 0, 8'h44);
        tick(); #1;
        check("t4.idle", 32'(c_out_valid), 32'd0);
        check("t4.in_ready", 32'(c_in_ready), 32'd1);

        // stalls on 0303, then back-to-back second vector
        flush_all();
        in_valid = 1'b1; in_vec = 16'h0303; in_tag = 8'h55; out_ready = 1'b0;
        tick(); in_valid = 1'b0; #1;
        beat_chk("t5.s0", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag, 1, 4'd0, 0, 0, 0, 8'h55);
        beat_chk("t5.d", d_out_valid, 4'(d_out_index), d_out_last, d_out_trunc, d_out_none, d_out_tag, 1, 4'd0, 1, 1, 0, 8'h55);
        tick(); out_ready = 1'b1; #1;
        beat_chk("t5.h0", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag, 1, 4'd0, 0, 0, 0, 8'h55);
        tick(); out_ready = 1'b0; #1;
        check("t5.s1", 32'(a_out_index), 32'd1);
        tick(); out_ready = 1'b1; #1;
        check("t5.h1", 32'(a_out_index), 32'd1);
        tick(); out_ready = 1'b0; #1;
        check("t5.s2", 32'(a_out_index), 32'd8);
        tick(); out_ready = 1'b1; #1;
        check("t5.h2", 32'(a_out_index), 32'd8);
        tick(); out_ready = 1'b0; #1;
        beat_chk("t5.s3", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag, 1, 4'd9, 1, 0, 0, 8'h55);
        tick(); out_ready = 1'b1; in_valid = 1'b1; in_vec = 16'h0010; in_tag = 8'h66; #1;
        check("t5.h3", 32'(a_out_index), 32'd9);
        check("t5.b2b_ready", 32'(a_in_ready), 32'd1);
        tick(); in_valid = 1'b0; #1;
        beat_chk("t5.v2", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag, 1, 4'd4, 1, 0, 0, 8'h66);
        tick(); #1;
        check("t5.idle", 32'(a_out_valid), 32'd0);

        // reset in the middle of a vector
        in_valid = 1'b1; in_vec = 16'hFFFF; in_tag = 8'h77; out_ready = 1'b0;
        tick(); in_valid = 1'b0; #1;
        check("t6.pre_rst_valid", 32'(a_out_valid), 32'd1);
        rst_n = 1'b0;
        tick(); rst_n = 1'b1; #1;
        beat_chk("t6.rst", a_out_valid, a_out_index, a_out_last, a_out_trunc, a_out_none, a_out_tag, 0, 4'd0, 0, 0, 0, 8'h00);

        // flush after two beats of FFFF
        in_valid = 1'b1; in_vec = 16'hFFFF; in_tag = 8'h77; out_ready = 1'b1;
        tick(); in_valid = 1'b0; #1;
        check("t6.b0", 32'(a_out_index), 32'd0);
        tick(); #1;
        check("t6.b1", 32'(a_out_index), 32'd1);
        tick(); out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; #1;
        check("t6.flush_idx", 32'(a_out_index), 32'd2);
        check("t6.flush_ready", 32'(a_in_ready), 32'd0);
        tick(); flush = 1'b0; in_valid = 1'b0; #1;
        check("t6.post_valid", 32'(a_out_valid), 32'd0);
        check("t6.post_ready", 32'(a_in_ready), 32'd1);
`ifdef MATCH_BIT_ITER_STATS_EN
        check("t6.stat_vec", a_svec, 32'd1);
        check("t6.stat_beat", a_sbeat, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
